softmax_backward: RTL and testbench
===================================

# softmax_backward

Computes the softmax input gradient for the transformer training path: grad_out_i = y_i·(dy_i − Σ_j y_j·dy_j). It takes the softmax outputs y and the upstream gradient dy, and returns dx. It is the reverse-direction counterpart of the forward softmax operator and uses the same active-low valid handshake. It uses signed fixed-point arithmetic with one shared multiplier, running two serial passes over the vector.

## Interface
- DATA_WIDTH, 16, width of each signed fixed-point element
- FRAC_BITS, 8, fractional bits (Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS)
- INPUT_NUM, 10, vector length N (≥2)
- clk_p  input  1  clock, all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- y_in  input  DATA_WIDTH*INPUT_NUM  softmax outputs y_i, element i at [DATA_WIDTH*i +: DATA_WIDTH]
- grad_in  input  DATA_WIDTH*INPUT_NUM  upstream gradient dy_i, same packing
- input_valid_n  input  1  low = request; held low for the whole transaction
- grad_out  output  DATA_WIDTH*INPUT_NUM  result dx_i, same packing, registered
- output_valid_n  output  1  low = grad_out valid, registered

## Operation
- States: IDLE, DOT, SCALE, DONE.
- IDLE:
  - If input_valid_n=0, latch y_in and grad_in, clear the accumulator and index, and go to DOT.
  - Later changes on the input buses are ignored until the next IDLE.
- DOT:
  - Each cycle: acc += y_i·dy_i, computed as a full-precision signed product.
  - acc width is 2·DATA_WIDTH+clog2(N); it never overflows.
  - After i=N−1, form s = sat(acc >>> FRAC_BITS) to DATA_WIDTH, reset the index, and go to SCALE.
- SCALE:
  - Each cycle: d = dy_i − s in DATA_WIDTH+1 bits.
  - grad_out element i = sat((y_i·d) >>> FRAC_BITS) to DATA_WIDTH.
  - After i=N−1, go to DONE.
- DONE: output_valid_n=0. Stay in DONE while input_valid_n=0, with no recompute. When input_valid_n=1, go to IDLE.
- Arithmetic rules:
  - Shifts are arithmetic and truncate toward −∞ (no rounding).
  - sat clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Abort: if input_valid_n=1 in DOT or SCALE, go to IDLE on the next edge. output_valid_n stays 1. Elements of grad_out already written in that pass keep their new values; the rest hold their old values.
- grad_out elements are written only in SCALE. They hold their value at all other times.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, grad_out=0, output_valid_n=1, acc=0, index=0. This applies in every state, including mid-transaction.
- Capture edge T: the edge at which IDLE samples input_valid_n=0.
- DOT occupies edges T+1..T+N.
- SCALE writes element i at edge T+N+1+i.
- output_valid_n goes low after edge T+2N; latency is 2N cycles (20 at default).
- output_valid_n returns to 1 on the first edge that samples input_valid_n=1 in DONE.
- IDLE can accept a new request on the edge after that.
- Minimum turnaround between transactions: 2N+2 cycles.

## Structure
- Shared package: state enum (IDLE/DOT/SCALE/DONE), and a sat function parameterized by output width.
- One sub-module, fx_mul_shift_sat: a signed DATA_WIDTH × (DATA_WIDTH+1) multiply, then arithmetic shift by FRAC_BITS, then saturate. It is combinational.
  - The DOT pass uses the raw product output (pre-shift) for accumulation.
  - The SCALE pass uses the saturated output.
  - One instance is time-shared by DOT and SCALE.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with input_valid_n=0 → grad_out=0 and output_valid_n=1. After release, capture occurs on the first edge.
- Basic (Q8.8, N=10): y0=y1=128 (0.5), dy0=256, all other y and dy = 0.
  - Expected s=128, grad_out0=64, grad_out1=−64, others 0.
  - output_valid_n goes low exactly 20 cycles after the capture edge.
- Uniform: all y=25 and all dy=256 → s=250, every grad_out=0 (truncation of 150>>>8).
- Saturation: y0=y1=32767, dy0=−32768, dy1=32767, rest 0.
  - Expected s=−128, grad_out0=−32768, grad_out1=32767.
- Abort and reset:
  - Raise input_valid_n at DOT cycle 5 → IDLE next edge, output_valid_n=1, grad_out unchanged. A re-issued basic vector then gives the correct result.
  - Separately, assert rst_n=0 mid-SCALE → all outputs are zero on the next edge.
- Handshake hold: after DONE, keep input_valid_n low for 5 cycles and change y_in.
  - Required: output_valid_n stays low and grad_out does not change.
  - Raising input_valid_n sets output_valid_n=1 after one edge.

Source files
------------

// File: rtl/softmax_backward_pkg.sv
// Shared types and helpers for the softmax backward unit.
// FSM state encoding plus a width-parameterised saturation helper.
package softmax_backward_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOT,
    SCALE,
    DONE
  } state_e;

  // Clamp v into the signed range of a w-bit value.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/softmax_backward_if.sv
// Vector bus for the softmax backward unit.
// Active-low valid on request and response sides.
interface softmax_backward_if #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_NUM  = 10
);
  logic [DATA_WIDTH*INPUT_NUM-1:0] y_in;
  logic [DATA_WIDTH*INPUT_NUM-1:0] grad_in;
  logic                            input_valid_n;
  logic [DATA_WIDTH*INPUT_NUM-1:0] grad_out;
  logic                            output_valid_n;

  modport master (
    output y_in,
    output grad_in,
    output input_valid_n,
    input  grad_out,
    input  output_valid_n
  );

  modport slave (
    input  y_in,
    input  grad_in,
    input  input_valid_n,
    output grad_out,
    output output_valid_n
  );
endinterface

// File: rtl/softmax_backward_fx_mul_shift_sat.sv
// Signed fixed-point multiply, arithmetic shift and saturate.
// Raw product is exposed for full-precision accumulation.
module fx_mul_shift_sat
  import softmax_backward_pkg::*;
#(
  parameter int DW = 16,
  parameter int FB = 8
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW:0]   b_i,
  output logic signed [2*DW:0] prod_o,
  output logic signed [DW-1:0] res_o
);

  logic signed [2*DW:0] shf;

  assign prod_o = a_i * b_i;
  assign shf    = prod_o >>> FB;
  assign res_o  = DW'(sat(64'(shf), DW));

endmodule

// File: rtl/softmax_backward.sv
// Softmax input gradient dx_i = y_i*(dy_i - sum_j y_j*dy_j).
// Two serial passes over one shared multiplier.
module softmax_backward
  import softmax_backward_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int INPUT_NUM  = 10
) (
  input logic               clk_p,
  input logic               rst_n,
  softmax_backward_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int N  = INPUT_NUM;
  localparam int IW = $clog2(N);
  localparam int AW = 2 * DW + $clog2(N);
  localparam int PW = 2 * DW + 1;
  localparam int VW = DW * N;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] s_q, s_d;
  logic [VW-1:0]        y_q, y_d;
  logic [VW-1:0]        dy_q, dy_d;
  logic [VW-1:0]        g_q, g_d;
  logic                 ovn_q, ovn_d;

  logic signed [DW-1:0] y_e;
  logic signed [DW-1:0] dy_e;
  logic signed [DW:0]   b;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] res;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sum_sh;
  logic                 last;

  assign y_e  = y_q[DW*idx_q +: DW];
  assign dy_e = dy_q[DW*idx_q +: DW];
  assign last = (idx_q == IW'(N - 1));

  // DOT multiplies by dy_i, SCALE by (dy_i - s); both fit DW+1 bits.
  always_comb begin
    if (state_q == SCALE)
      b = $signed({dy_e[DW-1], dy_e}) - $signed({s_q[DW-1], s_q});
    else
      b = $signed({dy_e[DW-1], dy_e});
  end

  fx_mul_shift_sat #(
    .DW(DW),
    .FB(FRAC_BITS)
  ) u_mul (
    .a_i   (y_e),
    .b_i   (b),
    .prod_o(prod),
    .res_o (res)
  );

  assign sum    = acc_q + AW'(prod);
  assign sum_sh = sum >>> FRAC_BITS;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    y_d     = y_q;
    dy_d    = dy_q;
    g_d     = g_q;
    ovn_d   = ovn_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.input_valid_n) begin
          y_d     = bus.y_in;
          dy_d    = bus.grad_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = DOT;
        end
      end
      DOT: begin
        if (bus.input_valid_n) begin
          state_d = IDLE;
        end else begin
          acc_d = sum;
          idx_d = idx_q + IW'(1);
          if (last) begin
            s_d     = DW'(sat(64'(sum_sh), DW));
            idx_d   = '0;
            state_d = SCALE;
          end
        end
      end
      SCALE: begin
        if (bus.input_valid_n) begin
          state_d = IDLE;
        end else begin
          g_d[DW*idx_q +: DW] = res;
          idx_d = idx_q + IW'(1);
          if (last) begin
            idx_d   = '0;
            ovn_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.input_valid_n) begin
          ovn_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      y_q     <= '0;
      dy_q    <= '0;
      g_q     <= '0;
      ovn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      y_q     <= y_d;
      dy_q    <= dy_d;
      g_q     <= g_d;
      ovn_q   <= ovn_d;
    end
  end

  assign bus.grad_out       = g_q;
  assign bus.output_valid_n = ovn_q;

endmodule

// File: tb/tb_softmax_backward.sv
// Directed bench for softmax_backward.
// Table vectors plus abort, reset and hold sequences.
module tb_softmax_backward;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int N  = 10;
  localparam int VW = DW * N;

  logic clk_p = 1'b0;
  logic rst_n;

  always #5 clk_p = ~clk_p;

  softmax_backward_if #(.DATA_WIDTH(DW), .INPUT_NUM(N)) bus ();

  softmax_backward #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB),
    .INPUT_NUM (N)
  ) dut (
    .clk_p(clk_p),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string         name;
    logic [VW-1:0] y;
    logic [VW-1:0] dy;
    logic [VW-1:0] ex;
  } vec_t;

  vec_t tv[4];

  function automatic logic [VW-1:0] setel(
    input logic [VW-1:0] v, input int i, input int val);
    logic [VW-1:0] r;
    r = v;
    r[DW*i +: DW] = DW'(val);
    return r;
  endfunction

  function automatic int el(input logic [VW-1:0] v, input int i);
    logic signed [DW-1:0] e;
    e = v[DW*i +: DW];
    return int'(e);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm,
                      input logic [VW-1:0] act,
                      input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_elems(input string nm, input logic [VW-1:0] ex);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s[%0d]", nm, i), el(bus.grad_out, i), el(ex, i));
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  // Count edges after the capture edge until output_valid_n falls.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 4 * N; k++) begin
      step();
      if (!bus.output_valid_n) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [VW-1:0] y,
                         input logic [VW-1:0] dy,
                         output int lat);
    bus.y_in          = y;
    bus.grad_in       = dy;
    bus.input_valid_n = 1'b0;
    step();
    wait_done(lat);
  endtask

  task automatic release_txn(input string nm);
    bus.input_valid_n = 1'b1;
    step();
    chk({nm, "_ovn_rel"}, int'(bus.output_valid_n), 1);
    step();
  endtask

  initial begin
    int            lat;
    logic [VW-1:0] prev;
    logic [VW-1:0] z;
    z = '0;

    tv[0].name = "basic";
    tv[0].y    = setel(setel(z, 0, 128), 1, 128);
    tv[0].dy   = setel(z, 0, 256);
    tv[0].ex   = setel(setel(z, 0, 64), 1, -64);

    tv[1].name = "uniform";
    tv[1].y    = z;
    tv[1].dy   = z;
    for (int i = 0; i < N; i++) begin
      tv[1].y  = setel(tv[1].y, i, 25);
      tv[1].dy = setel(tv[1].dy, i, 256);
    end
    tv[1].ex   = z;

    tv[2].name = "sat";
    tv[2].y    = setel(setel(z, 0, 32767), 1, 32767);
    tv[2].dy   = setel(setel(z, 0, -32768), 1, 32767);
    tv[2].ex   = setel(setel(z, 0, -32768), 1, 32767);

    tv[3].name = "neg";
    tv[3].y    = setel(setel(z, 0, 64), 1, 192);
    tv[3].dy   = setel(setel(z, 0, 512), 1, -256);
    tv[3].ex   = setel(setel(z, 0, 144), 1, -144);

    // Reset with request already pending
    rst_n             = 1'b0;
    bus.input_valid_n = 1'b0;
    bus.y_in          = tv[0].y;
    bus.grad_in       = tv[0].dy;
    repeat (3) step();
    chkv("rst_grad", bus.grad_out, z);
    chk("rst_ovn", int'(bus.output_valid_n), 1);
    rst_n = 1'b1;
    step();
    wait_done(lat);
    chk("rst_first_lat", lat, 2 * N);
    check_elems("rst_first", tv[0].ex);
    release_txn("rst_first");

    for (int t = 0; t < 4; t++) begin
      run_txn(tv[t].y, tv[t].dy, lat);
      chk({tv[t].name, "_lat"}, lat, 2 * N);
      check_elems(tv[t].name, tv[t].ex);
      release_txn(tv[t].name);
    end

    // Abort during DOT
    prev              = bus.grad_out;
    bus.y_in          = tv[0].y;
    bus.grad_in       = tv[0].dy;
    bus.input_valid_n = 1'b0;
    step();
    repeat (4) step();
    bus.input_valid_n = 1'b1;
    step();
    chk("abort_ovn", int'(bus.output_valid_n), 1);
    chkv("abort_grad", bus.grad_out, prev);
    repeat (3) step();
    chk("abort_ovn_idle", int'(bus.output_valid_n), 1);
    chkv("abort_grad_idle", bus.grad_out, prev);
    run_txn(tv[0].y, tv[0].dy, lat);
    chk("reissue_lat", lat, 2 * N);
    check_elems("reissue", tv[0].ex);
    release_txn("reissue");

    // Reset mid-SCALE after two elements are written
    bus.y_in          = tv[3].y;
    bus.grad_in       = tv[3].dy;
    bus.input_valid_n = 1'b0;
    step();
    repeat (N + 2) step();
    chk("scale_el0", el(bus.grad_out, 0), 144);
    chk("scale_el1", el(bus.grad_out, 1), -144);
    chk("scale_ovn", int'(bus.output_valid_n), 1);
    rst_n = 1'b0;
    step();
    chkv("midrst_grad", bus.grad_out, z);
    chk("midrst_ovn", int'(bus.output_valid_n), 1);
    rst_n             = 1'b1;
    bus.input_valid_n = 1'b1;
    step();

    // Hold in DONE while inputs change
    run_txn(tv[0].y, tv[0].dy, lat);
    chk("hold_lat", lat, 2 * N);
    for (int k = 0; k < 5; k++) begin
      bus.y_in    = tv[1].y;
      bus.grad_in = tv[1].dy;
      step();
      chk($sformatf("hold_ovn%0d", k), int'(bus.output_valid_n), 0);
      chkv($sformatf("hold_grad%0d", k), bus.grad_out, tv[0].ex);
    end
    release_txn("hold");
    chkv("hold_after_grad", bus.grad_out, tv[0].ex);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
